data_mem_resp: RTL

- Data-memory responder that services the CPU core's load and store port. It is the target end of the core's memory interface.
- Accepts one read or write request at a time, with byte, half or word size.
- Each request takes a programmable number of wait states. The block then commits the write or returns the lane-aligned, sign- or zero-extended read data, and pulses an acknowledge.
- Sits beside the core in the SoC top and is backed by an internal synchronous RAM.

---
 rtl/data_mem_resp.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/data_mem_resp.sv
// Data-memory responder for the core's load/store port.
// One request in flight at a time: IDLE accepts, WAIT burns the programmed
// wait states, and the RAM commit happens on the edge that enters RESP, which
// then pulses ack for one cycle.
module data_mem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_w_i,
  input  logic        res_w_i_h,
  input  logic [31:0] mem_addr_w_i,
  input  logic [31:0] mem_data_in_w_i,
  input  logic        mem_wr_w_i_h,
  input  logic        mem_rd_w_i_h,
  input  logic [1:0]  mem_wr_byte_sel_w_i,
  input  logic [1:0]  mem_rd_byte_sel_w_i,
  input  logic        mem_rd_unsigned_w_i_h,
  output logic [31:0] mem_data_w_o,
  output logic        mem_ack_w_o_h,
  output logic        mem_err_w_o_h,
  output logic        mem_busy_w_o_h
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        commit;

  // captured request
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        wr_q, both_q, uns_q;

  // request as seen at commit time: live inputs when committing straight
  // out of IDLE (WAIT_STATES=0), captured copy otherwise
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_wr, req_both, req_uns, req_err;
  logic [ADDR_W-1:0] req_idx;
  logic [3:0]  req_be;
  logic [31:0] req_wlanes;

  logic [31:0] ram [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic        err_q;

  // lane select + sign/zero extension of a fetched word
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // pick live vs captured request fields
  always_comb begin
    if (state_q == S_IDLE) begin
      req_addr  = mem_addr_w_i;
      req_wdata = mem_data_in_w_i;
      req_wr    = mem_wr_w_i_h;
      req_both  = mem_wr_w_i_h & mem_rd_w_i_h;
      req_size  = mem_wr_w_i_h ? mem_wr_byte_sel_w_i : mem_rd_byte_sel_w_i;
      req_uns   = mem_rd_unsigned_w_i_h;
    end else begin
      req_addr  = addr_q;
      req_wdata = wdata_q;
      req_wr    = wr_q;
      req_both  = both_q;
      req_size  = size_q;
      req_uns   = uns_q;
    end
  end

  // error classification, lane enables and replicated store data
  always_comb begin
    req_idx = req_addr[ADDR_W+1:2];
    req_err = req_both
            | (req_size == 2'b11)
            | ((req_size == 2'b01) & req_addr[0])
            | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
            | ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
    req_be     = 4'hF;
    req_wlanes = req_wdata;
    case (req_size)
      2'b00: begin
        req_be     = 4'b0001 << req_addr[1:0];
        req_wlanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be     = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wlanes = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // next-state / wait counter / commit strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_wr_w_i_h | mem_rd_w_i_h) begin
          if (WAIT_STATES == 0) begin
            commit  = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state, counter and response registers
  always_ff @(posedge clk_w_i) begin
    if (res_w_i_h) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        if (req_err) begin
          rdata_q <= 32'd0;
          err_q   <= 1'b1;
        end else begin
          err_q <= 1'b0;
          if (!req_wr) rdata_q <= load_ext(ram[req_idx], req_addr[1:0], req_size, req_uns);
        end
      end
    end
  end

  // capture the request on accept; ignored until the next accept
  always_ff @(posedge clk_w_i) begin
    if (res_w_i_h) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      wr_q    <= 1'b0;
      both_q  <= 1'b0;
      uns_q   <= 1'b0;
    end else if (state_q == S_IDLE && (mem_wr_w_i_h | mem_rd_w_i_h)) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      size_q  <= req_size;
      wr_q    <= req_wr;
      both_q  <= req_both;
      uns_q   <= req_uns;
    end
  end

  // RAM store; reset suppresses a pending write, contents are never cleared
  always_ff @(posedge clk_w_i) begin
    if (!res_w_i_h && commit && req_wr && !req_err) begin
      for (int i = 0; i < 4; i++)
        if (req_be[i]) ram[req_idx][8*i +: 8] <= req_wlanes[8*i +: 8];
    end
  end

  assign mem_data_w_o   = rdata_q;
  assign mem_ack_w_o_h  = (state_q == S_RESP);
  assign mem_busy_w_o_h = (state_q != S_IDLE);
  assign mem_err_w_o_h  = (state_q == S_RESP) & err_q;

endmodule
